// File: rtl/vending_fsm_multi.sv
// Multi-product coin vending controller with overflow rejection, refund and change return.
// Optional idle auto-refund built when VEND_TIMEOUT_EN is defined.
module vending_fsm_multi #(
    parameter int NUM_PROD = 4,
    parameter int CRED_W = 6,
    parameter logic [NUM_PROD*CRED_W-1:0] PRICES = {6'd5, 6'd4, 6'd3, 6'd2},
    parameter int COIN1_VAL = 2,
    parameter int COIN2_VAL = 3,
    parameter int COIN3_VAL = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          moneda,
    input  logic [NUM_PROD-1:0] comprar,
    input  logic                cancelar,
    output logic [NUM_PROD-1:0] listo,
    output logic [NUM_PROD-1:0] vend,
    output logic [CRED_W-1:0]   total,
    output logic                cambio,
    output logic                coin_rej,
    output logic                busy,
    output logic                tmo
);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    localparam logic [CRED_W:0] C1 = (CRED_W+1)'(COIN1_VAL);
    localparam logic [CRED_W:0] C2 = (CRED_W+1)'(COIN2_VAL);
    localparam logic [CRED_W:0] C3 = (CRED_W+1)'(COIN3_VAL);

    state_t state_q, state_n;
    logic [CRED_W-1:0] credit_q, credit_n, price_sel;
    logic [NUM_PROD-1:0] sel_q, sel_n, afford, buy_oh;
    logic [CRED_W:0] coin_v, sum;
    logic rej_q, rej_n, tmo_q, tmo_n;
    logic coin_in, coin_acc, tmo_hit;

    always_comb begin
        coin_v = '0;
        case (moneda)
            2'b01:   coin_v = C1;
            2'b10:   coin_v = C2;
            2'b11:   coin_v = C3;
            default: coin_v = '0;
        endcase
    end

    assign coin_in = (moneda != 2'b00);
    assign sum = {1'b0, credit_q} + coin_v;

    // Lowest affordable requested product wins.
    always_comb begin
        afford = '0;
        buy_oh = '0;
        price_sel = '0;
        for (int i = 0; i < NUM_PROD; i++)
            afford[i] = credit_q >= PRICES[i*CRED_W +: CRED_W];
        for (int i = NUM_PROD - 1; i >= 0; i--) begin
            if (comprar[i] && afford[i]) begin
                buy_oh = '0;
                buy_oh[i] = 1'b1;
                price_sel = PRICES[i*CRED_W +: CRED_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            credit_q <= '0;
            sel_q    <= '0;
            rej_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            credit_q <= credit_n;
            sel_q    <= sel_n;
            rej_q    <= rej_n;
            tmo_q    <= tmo_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        credit_n = credit_q;
        sel_n    = sel_q;
        coin_acc = 1'b0;
        tmo_n    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (coin_in && !sum[CRED_W]) begin
                    coin_acc = 1'b1;
                    credit_n = sum[CRED_W-1:0];
                    state_n  = CREDIT;
                end
            end
            CREDIT: begin
                if (cancelar) begin
                    state_n = CHANGE;
                end else if (|buy_oh) begin
                    state_n  = VEND;
                    sel_n    = buy_oh;
                    credit_n = credit_q - price_sel;
                end else if (coin_in && !sum[CRED_W]) begin
                    coin_acc = 1'b1;
                    credit_n = sum[CRED_W-1:0];
                end else if (tmo_hit) begin
                    state_n = CHANGE;
                    tmo_n   = 1'b1;
                end
            end
            VEND: begin
                state_n = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (credit_q != '0)
                    credit_n = credit_q - 1'b1;
                if (credit_q <= CRED_W'(1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        rej_n = coin_in && !coin_acc;
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_n;
    logic buy_rej;

    assign buy_rej = (|comprar) && !(|buy_oh);
    assign tmo_hit = (state_q == CREDIT) && (cnt_q >= TMO_LAST);

    // Any activity or fresh entry into CREDIT restarts the idle count.
    always_comb begin
        cnt_n = '0;
        if (state_q == CREDIT && state_n == CREDIT && !coin_acc && !buy_rej)
            cnt_n = cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_n;
    end
`else
    localparam int unused_tmo_cyc = TIMEOUT_CYC;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        listo = '0;
        vend  = '0;
        if (state_q == CREDIT)
            listo = afford;
        if (state_q == VEND)
            vend = sel_q;
    end

    assign total    = credit_q;
    assign cambio   = (state_q == CHANGE);
    assign busy     = (state_q == VEND) || (state_q == CHANGE);
    assign coin_rej = rej_q;
    assign tmo      = tmo_q;

endmodule

// File: tb/tb_vending_fsm_multi.sv
// Bench for vending_fsm_multi: vector table plus hand-written corner sequences.
// Expected outputs are queued at drive time and popped one edge later.
module tb_vending_fsm_multi;

    logic       clk;
    logic       reset_n;
    logic [1:0] moneda;
    logic [3:0] comprar;
    logic       cancelar;
    logic [3:0] listo;
    logic [3:0] vend;
    logic [5:0] total;
    logic       cambio;
    logic       coin_rej;
    logic       busy;
    logic       tmo;

    typedef struct packed {
        logic [3:0] listo;
        logic [3:0] vend;
        logic [5:0] total;
        logic       cambio;
        logic       rej;
        logic       busy;
        logic       tmo;
    } exp_t;

    typedef struct {
        logic [1:0] m;
        logic [3:0] c;
        logic       x;
        exp_t       e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    vending_fsm_multi #(
        .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .moneda(moneda),
        .comprar(comprar),
        .cancelar(cancelar),
        .listo(listo),
        .vend(vend),
        .total(total),
        .cambio(cambio),
        .coin_rej(coin_rej),
        .busy(busy),
        .tmo(tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] l, input logic [3:0] v,
                                input int t, input logic cb, input logic rj,
                                input logic bs, input logic tm);
        exp_t e;
        e.listo  = l;
        e.vend   = v;
        e.total  = 6'(t);
        e.cambio = cb;
        e.rej    = rj;
        e.busy   = bs;
        e.tmo    = tm;
        return e;
    endfunction

    task automatic add(input logic [1:0] m, input logic [3:0] c,
                       input logic x, input exp_t e);
        vec_t v;
        v.m = m;
        v.c = c;
        v.x = x;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [1:0] m, input logic [3:0] c,
                        input logic x, input exp_t e, input string name);
        exp_t got;
        exp_t want;
        moneda   = m;
        comprar  = c;
        cancelar = x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {listo, vend, total, cambio, coin_rej, busy, tmo};
        want = sb.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got listo=%b vend=%b total=%0d cambio=%b rej=%b busy=%b tmo=%b, expected listo=%b vend=%b total=%0d cambio=%b rej=%b busy=%b tmo=%b",
                     name, got.listo, got.vend, got.total, got.cambio,
                     got.rej, got.busy, got.tmo, want.listo, want.vend,
                     want.total, want.cambio, want.rej, want.busy, want.tmo);
        end
    endtask

    exp_t z;

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        moneda   = 2'b00;
        comprar  = 4'b0000;
        cancelar = 1'b0;
        z = mk(4'b0000, 4'b0000, 0, 0, 0, 0, 0);

        step(2'b00, 4'b0000, 1'b0, z, "reset1");
        step(2'b00, 4'b0000, 1'b0, z, "reset2");
        reset_n = 1'b1;

        // coin then cheapest product, exact price
        add(2'b01, 4'b0000, 1'b0, mk(4'b0001, 4'b0000, 2, 0, 0, 0, 0));
        add(2'b00, 4'b0001, 1'b0, mk(4'b0000, 4'b0001, 0, 0, 0, 1, 0));
        add(2'b00, 4'b0000, 1'b0, z);
        // credit 8, buy product 3, three change units
        add(2'b11, 4'b0000, 1'b0, mk(4'b0111, 4'b0000, 4, 0, 0, 0, 0));
        add(2'b11, 4'b0000, 1'b0, mk(4'b1111, 4'b0000, 8, 0, 0, 0, 0));
        add(2'b00, 4'b1000, 1'b0, mk(4'b0000, 4'b1000, 3, 0, 0, 1, 0));
        for (int t = 3; t >= 1; t--)
            add(2'b00, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, t, 1, 0, 1, 0));
        add(2'b00, 4'b0000, 1'b0, z);
        // credit 3, partially affordable request, coin during VEND
        add(2'b10, 4'b0000, 1'b0, mk(4'b0011, 4'b0000, 3, 0, 0, 0, 0));
        add(2'b00, 4'b1010, 1'b0, mk(4'b0000, 4'b0010, 0, 0, 0, 1, 0));
        add(2'b10, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, 0, 0, 1, 0, 0));
        add(2'b00, 4'b0000, 1'b0, z);
        // credit 7, cancel with simultaneous coin
        add(2'b01, 4'b0000, 1'b0, mk(4'b0001, 4'b0000, 2, 0, 0, 0, 0));
        add(2'b10, 4'b0000, 1'b0, mk(4'b1111, 4'b0000, 5, 0, 0, 0, 0));
        add(2'b01, 4'b0000, 1'b0, mk(4'b1111, 4'b0000, 7, 0, 0, 0, 0));
        add(2'b01, 4'b0000, 1'b1, mk(4'b0000, 4'b0000, 7, 1, 1, 1, 0));
        for (int t = 6; t >= 1; t--)
            add(2'b00, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, t, 1, 0, 1, 0));
        add(2'b00, 4'b0000, 1'b0, z);

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].m, tbl[i].c, tbl[i].x, tbl[i].e, $sformatf("vec%0d", i));

        // cancel in IDLE is ignored; unaffordable request is ignored
        step(2'b00, 4'b0000, 1'b1, z, "cancel_idle");
        step(2'b01, 4'b0000, 1'b0, mk(4'b0001, 4'b0000, 2, 0, 0, 0, 0), "coin2");
        step(2'b00, 4'b1000, 1'b0, mk(4'b0001, 4'b0000, 2, 0, 0, 0, 0), "unaffordable");
        step(2'b00, 4'b0000, 1'b1, mk(4'b0000, 4'b0000, 2, 1, 0, 1, 0), "cancel2a");
        step(2'b00, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, 1, 1, 0, 1, 0), "cancel2b");
        step(2'b00, 4'b0000, 1'b0, z, "cancel2_idle");

        // fill to 60, overflowing coin rejected
        for (int k = 1; k <= 15; k++)
            step(2'b11, 4'b0000, 1'b0,
                 mk((k == 1) ? 4'b0111 : 4'b1111, 4'b0000, 4 * k, 0, 0, 0, 0),
                 $sformatf("fill%0d", k));
        step(2'b11, 4'b0000, 1'b0, mk(4'b1111, 4'b0000, 60, 0, 1, 0, 0), "overflow");
        step(2'b00, 4'b0000, 1'b0, mk(4'b1111, 4'b0000, 60, 0, 0, 0, 0), "overflow_after");
        step(2'b00, 4'b0000, 1'b1, mk(4'b0000, 4'b0000, 60, 1, 0, 1, 0), "drain60");
        for (int t = 59; t >= 55; t--)
            step(2'b00, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, t, 1, 0, 1, 0),
                 $sformatf("drain%0d", t));

        // reset mid-CHANGE abandons the refund
        reset_n = 1'b0;
        step(2'b00, 4'b0000, 1'b0, z, "reset_mid_change");
        reset_n = 1'b1;
        step(2'b00, 4'b0000, 1'b0, z, "after_reset");

        step(2'b11, 4'b0000, 1'b0, mk(4'b0111, 4'b0000, 4, 0, 0, 0, 0), "tmo_coin");
`ifdef VEND_TIMEOUT_EN
        for (int k = 1; k <= 9; k++)
            step(2'b00, 4'b0000, 1'b0, mk(4'b0111, 4'b0000, 4, 0, 0, 0, 0),
                 $sformatf("tmo_wait%0d", k));
        step(2'b00, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, 4, 1, 0, 1, 1), "tmo_fire");
`else
        for (int k = 1; k <= 100; k++)
            step(2'b00, 4'b0000, 1'b0, mk(4'b0111, 4'b0000, 4, 0, 0, 0, 0),
                 $sformatf("hold%0d", k));
        step(2'b00, 4'b0000, 1'b1, mk(4'b0000, 4'b0000, 4, 1, 0, 1, 0), "hold_cancel");
`endif
        for (int t = 3; t >= 1; t--)
            step(2'b00, 4'b0000, 1'b0, mk(4'b0000, 4'b0000, t, 1, 0, 1, 0),
                 $sformatf("refund%0d", t));
        step(2'b00, 4'b0000, 1'b0, z, "refund_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
